cmp_bsearch_ctrl: RTL and testbench
===================================

Name: cmp_bsearch_ctrl

Overview:
- Iterative binary-search controller over a sorted table of 16-bit entries, held in an external synchronous-read memory.
- Sits directly upstream of the compare stage: drives its operand inputs (key vs. table entry) and consumes its 3-bit one-hot result.
- Reports hit/miss and the match index, or the insertion point on a miss, to the hash lookup logic.

Parameters:
- DEPTH, 16, number of table entries (power of two, >=2)
- ADDR_W, 4, log2(DEPTH)
- CMP_LAT, 1, cycles from operand register update to a valid cmp_res (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- start  input  1  begin search; sampled only in IDLE
- key  input  16  search key; captured on an accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the result is valid
- found  output  1  key present; valid with done, held until next start
- index  output  ADDR_W+1  match index on hit, insertion point (0..DEPTH) on miss
- tbl_addr  output  ADDR_W  table read address
- tbl_data  input  16  table read data, valid 1 cycle after tbl_addr
- cmp_a  output  16  compare operand 0 (key)
- cmp_b  output  16  compare operand 1 (table entry)
- cmp_res  input  3  compare result: bit2 = a>b, bit1 = a==b, bit0 = a<b

Behaviour:
- Reset is synchronous and active-low: reset==0 at a posedge clk forces state to IDLE.
- Reset values: busy=0, done=0, found=0, index=0, tbl_addr=0, cmp_a=0, cmp_b=0, lo=0, hi=DEPTH-1.
- A reset asserted mid-search aborts the search; no done pulse is produced.
- States: IDLE, FETCH, LOAD, WAIT, DECIDE, DONE.
- IDLE: on start=1, capture key, set lo=0, hi=DEPTH-1, busy=1, go to FETCH.
- start while busy is ignored, and key is not recaptured.
- FETCH: mid = (lo+hi)>>1, computed at ADDR_W+1 bits with no overflow; tbl_addr <= mid; go to LOAD.
- LOAD: cmp_a <= key, cmp_b <= tbl_data; go to WAIT if CMP_LAT>1, else to DECIDE.
- WAIT: hold for CMP_LAT-1 cycles, then go to DECIDE.
- DECIDE samples cmp_res:
  - eq: found=1, index=mid, go to DONE.
  - lt (key<entry): if mid==0, found=0, index=0, go to DONE; else hi=mid-1, then if lo>hi miss with index=lo, else go to FETCH.
  - gt: lo=mid+1; if lo>hi, found=0, index=lo (may equal DEPTH), go to DONE; else go to FETCH.
  - cmp_res not one-hot: treated as gt.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. A start in the DONE cycle is ignored.
- Cost per probe: 2+CMP_LAT cycles.
- done is asserted probes*(2+CMP_LAT) cycles after the edge that accepted start.
- Maximum probes: ADDR_W+1.
- Operands change only in LOAD and are otherwise stable, so the compare stage may register freely.

Optional Feature:
- Macro: CMP_BSEARCH_PROBE_CNT_EN.
- When defined:
  - Adds output probes[ADDR_W:0], a count of DECIDE visits in the current search.
  - Cleared on accepted start and on reset; holds its value after done.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Table[i]=10*i (0..150), CMP_LAT=1, key=70 -> first probe at mid 7 hits; found=1, index=7, done 3 cycles after start, probes=1.
- Same table, key=0 -> mids 7,3,1,0; found=1, index=0, done after 12 cycles, probes=4.
- Same table, key=35 -> mids 7,3,5,4; found=0, index=4; key=155 -> mids 7,11,13,14,15; found=0, index=16.
- CMP_LAT=3, key=120 -> mids 7,11,13,12; found=1, index=12, done after 4*5=20 cycles; cmp_a/cmp_b stable throughout each WAIT.
- start pulsed again during a busy search, and a reset=0 pulse mid-search -> second start ignored, result unchanged; after reset, busy=0, done never pulses, next start searches normally.

Source files
------------

// File: rtl/cmp_bsearch_ctrl_if.sv
// -----------------------------------------------------------------------------
// cmp_bsearch_ctrl_if
// Request/response bus between the hash lookup logic (master) and the
// binary-search controller (slave).
//
// Signals:
//   start   master -> slave  begin a search (sampled only while idle)
//   key     master -> slave  16-bit search key, captured on an accepted start
//   busy    slave -> master  high from accepted start until the result
//   done    slave -> master  one-cycle pulse when found/index are valid
//   found   slave -> master  key present in the table
//   index   slave -> master  match index on hit, insertion point on miss
//   probes  slave -> master  DECIDE visits in the current search
//                            (only with CMP_BSEARCH_PROBE_CNT_EN defined)
// -----------------------------------------------------------------------------
interface cmp_bsearch_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [15:0]       key;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W:0]   index;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
    logic [ADDR_W:0]   probes;
`endif

    modport master (
        output start,
        output key,
        input  busy,
        input  done,
        input  found,
        input  index
`ifdef CMP_BSEARCH_PROBE_CNT_EN
        , input probes
`endif
    );

    modport slave (
        input  start,
        input  key,
        output busy,
        output done,
        output found,
        output index
`ifdef CMP_BSEARCH_PROBE_CNT_EN
        , output probes
`endif
    );
endinterface

// File: rtl/cmp_bsearch_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_bsearch_ctrl
// Iterative binary-search controller over a sorted table of 16-bit entries held
// in an external memory. Each probe reads one entry, presents key/entry to the
// downstream compare stage and steers the search window from its one-hot
// result. Reports hit + index, or miss + insertion point (0..DEPTH).
//
// Optional feature macro: CMP_BSEARCH_PROBE_CNT_EN
//   When defined, bus.probes counts DECIDE visits in the current search
//   (cleared on accepted start and on reset, held after done).
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   bus         request/response bus (slave side): start, key, busy, done,
//               found, index [, probes]
//   o_tbl_addr  table read address
//   i_tbl_data  table read data, valid one cycle after o_tbl_addr
//   o_cmp_a     compare operand 0 (key)
//   o_cmp_b     compare operand 1 (table entry)
//   i_cmp_res   compare result: bit2 = a>b, bit1 = a==b, bit0 = a<b
//
// Parameters:
//   DEPTH    number of table entries (power of two, >= 2)
//   ADDR_W   log2(DEPTH)
//   CMP_LAT  cycles from operand update to a valid i_cmp_res (>= 1)
// -----------------------------------------------------------------------------
module cmp_bsearch_ctrl #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int CMP_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    cmp_bsearch_ctrl_if.slave   bus,
    output logic [ADDR_W-1:0]   o_tbl_addr,
    input  logic [15:0]         i_tbl_data,
    output logic [15:0]         o_cmp_a,
    output logic [15:0]         o_cmp_b,
    input  logic [2:0]          i_cmp_res
);

    // WAIT lasts CMP_LAT-1 cycles; the counter is loaded with CMP_LAT-2 and
    // DECIDE follows the cycle in which it reads zero.
    localparam int                WAIT_W    = (CMP_LAT > 2) ? $clog2(CMP_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((CMP_LAT > 1) ? (CMP_LAT - 2) : 0);
    localparam logic [ADDR_W:0]   HI_INIT   = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [15:0]         r_key;
    logic [ADDR_W:0]     r_lo;
    logic [ADDR_W:0]     r_hi;
    logic [ADDR_W:0]     r_mid;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_busy;
    logic                r_done;
    logic                r_found;
    logic [ADDR_W:0]     r_index;
    logic [ADDR_W-1:0]   r_tbl_addr;
    logic [15:0]         r_cmp_a;
    logic [15:0]         r_cmp_b;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
    logic [ADDR_W:0]     r_probes;
`endif

    // Midpoint is formed one bit wider than the window bounds so lo+hi can
    // never wrap, whatever DEPTH is.
    logic [ADDR_W+1:0]   w_sum;
    logic [ADDR_W:0]     w_mid;
    logic [ADDR_W:0]     w_mid_inc;
    logic [ADDR_W:0]     w_mid_dec;

    assign w_sum     = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid     = w_sum[ADDR_W+1:1];
    assign w_mid_inc = r_mid + (ADDR_W + 1)'(1);
    assign w_mid_dec = r_mid - (ADDR_W + 1)'(1);

    // Exact one-hot decode of the compare result. Anything that is not
    // exactly "lt" or "eq" (including gt, zero and multi-hot codes) falls
    // through to the gt branch.
    logic [2:0] w_is_bit;
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_res_decode
            assign w_is_bit[gi] = (i_cmp_res == (3'b001 << gi));
        end
    endgenerate

    logic w_lt;
    logic w_eq;
    assign w_lt = w_is_bit[0];
    assign w_eq = w_is_bit[1];

    // Outcome of the current probe, consumed only in DECIDE.
    logic              w_finish;
    logic              w_res_found;
    logic [ADDR_W:0]   w_res_index;
    logic [ADDR_W:0]   w_lo_next;
    logic [ADDR_W:0]   w_hi_next;

    always_comb begin
        w_finish    = 1'b0;
        w_res_found = 1'b0;
        w_res_index = r_lo;
        w_lo_next   = r_lo;
        w_hi_next   = r_hi;
        if (w_eq) begin
            w_finish    = 1'b1;
            w_res_found = 1'b1;
            w_res_index = r_mid;
        end else if (w_lt) begin
            if (r_mid == '0) begin
                // Key below entry 0: insertion point is the table start.
                w_finish    = 1'b1;
                w_res_index = '0;
            end else begin
                w_hi_next = w_mid_dec;
                if (r_lo > w_mid_dec) begin
                    w_finish    = 1'b1;
                    w_res_index = r_lo;
                end
            end
        end else begin
            w_lo_next = w_mid_inc;
            if (w_mid_inc > r_hi) begin
                // lo may reach DEPTH here: key above every entry.
                w_finish    = 1'b1;
                w_res_index = w_mid_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_lo       <= '0;
            r_hi       <= HI_INIT;
            r_mid      <= '0;
            r_wait     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_found    <= 1'b0;
            r_index    <= '0;
            r_tbl_addr <= '0;
            r_cmp_a    <= '0;
            r_cmp_b    <= '0;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
            r_probes   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_key   <= bus.key;
                        r_lo    <= '0;
                        r_hi    <= HI_INIT;
                        r_busy  <= 1'b1;
                        r_found <= 1'b0;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
                        r_probes <= '0;
`endif
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // lo <= hi <= DEPTH-1 here, so mid always fits ADDR_W bits.
                    r_mid      <= w_mid;
                    r_tbl_addr <= w_mid[ADDR_W-1:0];
                    r_state    <= S_LOAD;
                end

                S_LOAD: begin
                    // The only place operands move; the compare stage may
                    // register them freely.
                    r_cmp_a <= r_key;
                    r_cmp_b <= i_tbl_data;
                    if (CMP_LAT > 1) begin
                        r_wait  <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_DECIDE;
                    end
                end

                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end

                S_DECIDE: begin
`ifdef CMP_BSEARCH_PROBE_CNT_EN
                    r_probes <= r_probes + (ADDR_W + 1)'(1);
`endif
                    r_lo <= w_lo_next;
                    r_hi <= w_hi_next;
                    if (w_finish) begin
                        r_found <= w_res_found;
                        r_index <= w_res_index;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end

                S_DONE: begin
                    // done is visible for this single cycle; start is not
                    // looked at until IDLE.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.found  = r_found;
    assign bus.index  = r_index;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
    assign bus.probes = r_probes;
`endif
    assign o_tbl_addr = r_tbl_addr;
    assign o_cmp_a    = r_cmp_a;
    assign o_cmp_b    = r_cmp_b;

endmodule

// File: tb/tb_cmp_bsearch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_bsearch_ctrl
// Directed bench for cmp_bsearch_ctrl. Two instances share one table model
// (entry[i] = 10*i): u_a with a combinational compare stage (CMP_LAT=1) and
// u_b with a two-register compare pipeline (CMP_LAT=3). sel chooses which
// instance the current step drives and observes.
// -----------------------------------------------------------------------------
module tb_cmp_bsearch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        start_v = 1'b0;
    logic [15:0] key_v = 16'd0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] b_q[$];
    int          a_chg;

    always #5 clk = ~clk;

    cmp_bsearch_ctrl_if #(.ADDR_W(4)) ifa ();
    cmp_bsearch_ctrl_if #(.ADDR_W(4)) ifb ();

    assign ifa.start = start_v & ~sel;
    assign ifb.start = start_v & sel;
    assign ifa.key   = key_v;
    assign ifb.key   = key_v;

    logic [3:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic [15:0] cmpa_a, cmpb_a, cmpa_b, cmpb_b;
    logic [2:0]  res_a, res_b, pipe1_b, pipe2_b;

    function automatic logic [2:0] cmp3(input logic [15:0] a, input logic [15:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // Table: entry i holds 10*i; data follows the registered address.
    assign data_a = {12'd0, addr_a} * 16'd10;
    assign data_b = {12'd0, addr_b} * 16'd10;

    assign res_a = cmp3(cmpa_a, cmpb_a);

    always_ff @(posedge clk) begin
        pipe1_b <= cmp3(cmpa_b, cmpb_b);
        pipe2_b <= pipe1_b;
    end
    assign res_b = pipe2_b;

    cmp_bsearch_ctrl #(.DEPTH(16), .ADDR_W(4), .CMP_LAT(1)) u_a (
        .clk        (clk),
        .reset      (reset),
        .bus        (ifa),
        .o_tbl_addr (addr_a),
        .i_tbl_data (data_a),
        .o_cmp_a    (cmpa_a),
        .o_cmp_b    (cmpb_a),
        .i_cmp_res  (res_a)
    );

    cmp_bsearch_ctrl #(.DEPTH(16), .ADDR_W(4), .CMP_LAT(3)) u_b (
        .clk        (clk),
        .reset      (reset),
        .bus        (ifb),
        .o_tbl_addr (addr_b),
        .i_tbl_data (data_b),
        .o_cmp_a    (cmpa_b),
        .o_cmp_b    (cmpb_b),
        .i_cmp_res  (res_b)
    );

    logic        obs_busy, obs_done, obs_found;
    logic [4:0]  obs_index;
    logic [3:0]  obs_addr;
    logic [15:0] obs_cmp_a, obs_cmp_b;
    assign obs_busy  = sel ? ifb.busy  : ifa.busy;
    assign obs_done  = sel ? ifb.done  : ifa.done;
    assign obs_found = sel ? ifb.found : ifa.found;
    assign obs_index = sel ? ifb.index : ifa.index;
    assign obs_addr  = sel ? addr_b    : addr_a;
    assign obs_cmp_a = sel ? cmpa_b    : cmpa_a;
    assign obs_cmp_b = sel ? cmpb_b    : cmpb_a;
`ifdef CMP_BSEARCH_PROBE_CNT_EN
    logic [4:0]  obs_probes;
    assign obs_probes = sel ? ifb.probes : ifa.probes;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One search from start to result; poke_at >= 0 re-pulses start (with a
    // different key) that many cycles after acceptance.
    task automatic run_search(input logic s, input logic [15:0] k,
                              input logic exp_found, input logic [4:0] exp_idx,
                              input int exp_cyc, input int exp_probes,
                              input int poke_at, input string tag);
        int          cyc;
        logic [15:0] last_a, last_b;
        sel = s;
        @(negedge clk);
        key_v   = k;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        cyc = 0;
        check({tag, ".busy_on_start"}, 32'(obs_busy), 32'd1);
        last_a = obs_cmp_a;
        last_b = obs_cmp_b;
        a_chg  = 0;
        b_q.delete();
        while (obs_done !== 1'b1 && cyc < 200) begin
            if (cyc == poke_at) begin
                key_v   = 16'd70;
                start_v = 1'b1;
            end else begin
                start_v = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (obs_cmp_a !== last_a) begin
                a_chg++;
                last_a = obs_cmp_a;
            end
            if (obs_cmp_b !== last_b) begin
                b_q.push_back(obs_cmp_b);
                last_b = obs_cmp_b;
            end
        end
        start_v = 1'b0;
        $display("search %s key=%0d found=%0d index=%0d cycles=%0d", tag, k, obs_found, obs_index, cyc);
        check({tag, ".done_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".found"}, 32'(obs_found), 32'(exp_found));
        check({tag, ".index"}, 32'(obs_index), 32'(exp_idx));
        check({tag, ".busy_at_done"}, 32'(obs_busy), 32'd0);
        check({tag, ".cmp_a_key"}, 32'(obs_cmp_a), 32'(k));
`ifdef CMP_BSEARCH_PROBE_CNT_EN
        check({tag, ".probes"}, 32'(obs_probes), 32'(exp_probes));
`else
        if (exp_probes < 0) $display("note: negative probe expectation in %s", tag);
`endif
        // start during the DONE cycle must be ignored
        key_v   = 16'hFFFF;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        check({tag, ".done_pulse_end"}, 32'(obs_done), 32'd0);
        check({tag, ".start_in_done_ignored"}, 32'(obs_busy), 32'd0);
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        check("rst.busy",  32'(obs_busy),  32'd0);
        check("rst.done",  32'(obs_done),  32'd0);
        check("rst.found", 32'(obs_found), 32'd0);
        check("rst.index", 32'(obs_index), 32'd0);
        check("rst.addr",  32'(obs_addr),  32'd0);
        check("rst.cmp_a", 32'(obs_cmp_a), 32'd0);
        check("rst.cmp_b", 32'(obs_cmp_b), 32'd0);
        check("rst.busy_b", 32'(ifb.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // CMP_LAT=1 searches
        run_search(1'b0, 16'd70,  1'b1, 5'd7,  3,  1, -1, "hit70");
        run_search(1'b0, 16'd0,   1'b1, 5'd0,  12, 4, -1, "hit0");
        run_search(1'b0, 16'd35,  1'b0, 5'd4,  12, 4, -1, "miss35");
        run_search(1'b0, 16'd155, 1'b0, 5'd16, 15, 5, -1, "miss155");
        run_search(1'b0, 16'd5,   1'b0, 5'd1,  12, 4, -1, "miss5");

        // CMP_LAT=3: mids 7,11,13,12 -> entries 70,110,130,120
        run_search(1'b1, 16'd120, 1'b1, 5'd12, 20, 4, -1, "lat3_hit120");
        check("lat3.cmp_a_changes", 32'(a_chg), 32'd1);
        check("lat3.cmp_b_changes", 32'(b_q.size()), 32'd4);
        if (b_q.size() == 4) begin
            check("lat3.cmp_b0", 32'(b_q[0]), 32'd70);
            check("lat3.cmp_b1", 32'(b_q[1]), 32'd110);
            check("lat3.cmp_b2", 32'(b_q[2]), 32'd130);
            check("lat3.cmp_b3", 32'(b_q[3]), 32'd120);
        end

        // Start re-pulsed mid-search (key 70) must not disturb a key=35 search
        run_search(1'b0, 16'd35, 1'b0, 5'd4, 12, 4, 2, "busy_start");

        // Reset mid-search aborts without a done pulse
        sel = 1'b0;
        @(negedge clk);
        key_v   = 16'd155;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(obs_busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort.busy",  32'(obs_busy),  32'd0);
        check("abort.done",  32'(obs_done),  32'd0);
        check("abort.index", 32'(obs_index), 32'd0);
        check("abort.addr",  32'(obs_addr),  32'd0);
        check("abort.cmp_a", 32'(obs_cmp_a), 32'd0);
        check("abort.cmp_b", 32'(obs_cmp_b), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (obs_done === 1'b1 || obs_busy === 1'b1) seen++;
        end
        check("abort.no_done_after", 32'(seen), 32'd0);
        run_search(1'b0, 16'd70, 1'b1, 5'd7, 3, 1, -1, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
